// File: rtl/tbus_pkg.sv
// Shared types and helpers for the tri-state bus arbiter and its round-robin picker.
package tbus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRIVE = 2'd2,
        TURN  = 2'd3
    } tbus_state_e;

    localparam int PULLDOWN = 0;
    localparam int PULLUP   = 1;
    localparam int KEEPER   = 2;

    // Width of a pointer able to index n channels; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr wins.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          any
);

    logic [PW-1:0] idx_s;

    // Rotating scan from ptr; once any is set, later requests are masked out.
    always_comb begin
        win   = '0;
        any   = 1'b0;
        idx_s = '0;
        for (int i = 0; i < N; i++) begin
            idx_s      = PW'((int'(ptr) + i) % N);
            win[idx_s] = win[idx_s] | (req[idx_s] & ~any);
            any        = any | req[idx_s];
        end
    end

endmodule

// File: rtl/tbus_arbiter.sv
// Round-robin tri-state bus controller with break-before-make dead time and a
// configurable idle level (pulldown, pullup or keeper).
module tbus_arbiter
    import tbus_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int DEAD      = 2,
    parameter int IDLE_MODE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [CHANNELS-1:0]       grant,
    output logic [CHANNELS-1:0]       oe,
    output logic [WIDTH-1:0]          bus_out,
    output logic                      bus_valid,
    output logic                      idle
);

    localparam int PW = ptr_width(CHANNELS);
    // TURN is left when the counter reads zero, so loading DEAD-1 gives DEAD cycles.
    localparam logic [3:0] TURN_LOAD = (DEAD > 0) ? 4'(DEAD - 1) : 4'd0;

    tbus_state_e         state_q, state_d;
    logic [CHANNELS-1:0] owner_q, owner_d;
    logic [CHANNELS-1:0] grant_q, grant_d;
    logic [CHANNELS-1:0] oe_q, oe_d;
    logic [PW-1:0]       ptr_q, ptr_d, ptr_nxt;
    logic [3:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]    keep_q, keep_d;
    logic                valid_q, valid_d;
    logic                idle_q, idle_d;

    logic [CHANNELS-1:0] win_s;
    logic                any_s;
    logic                owner_req;
    logic [WIDTH-1:0]    din_sel;
    logic [WIDTH-1:0]    idle_lvl;

    rr_pick #(
        .N  (CHANNELS),
        .PW (PW)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .win (win_s),
        .any (any_s)
    );

    assign owner_req = |(req & owner_q);

    // Pointer one past the winner, and the current owner's data lane.
    always_comb begin
        ptr_nxt = '0;
        din_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ptr_nxt = ptr_nxt | ({PW{win_s[i]}} & PW'((i + 1) % CHANNELS));
            din_sel = din_sel | ({WIDTH{owner_q[i]}} & din[i*WIDTH +: WIDTH]);
        end
    end

    // Level presented whenever no channel drives.
    always_comb begin
        case (IDLE_MODE)
            PULLDOWN: idle_lvl = '0;
            PULLUP:   idle_lvl = '1;
            KEEPER:   idle_lvl = keep_q;
            default:  idle_lvl = '0;
        endcase
    end

    // Next state plus the output registers decoded from that next state.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        keep_d  = keep_q;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    state_d = GRANT;
                    owner_d = win_s;
                    ptr_d   = ptr_nxt;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (owner_req) begin
                    state_d = DRIVE;
                end else if (DEAD == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = TURN;
                    cnt_d   = TURN_LOAD;
                end
            end
            DRIVE: begin
                keep_d = din_sel;
                if (owner_req) begin
                    state_d = DRIVE;
                end else if (DEAD != 0) begin
                    state_d = TURN;
                    cnt_d   = TURN_LOAD;
                end else if (any_s) begin
                    state_d = GRANT;
                    owner_d = win_s;
                    ptr_d   = ptr_nxt;
                end else begin
                    state_d = IDLE;
                end
            end
            TURN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (any_s) begin
                    state_d = GRANT;
                    owner_d = win_s;
                    ptr_d   = ptr_nxt;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        grant_d = ((state_d == GRANT) || (state_d == DRIVE)) ? owner_d : '0;
        oe_d    = (state_d == DRIVE) ? owner_d : '0;
        valid_d = (state_d == DRIVE);
        idle_d  = (state_d == IDLE);
    end

    // State and output registers; reset clears oe at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= 4'd0;
            keep_q  <= '0;
            grant_q <= '0;
            oe_q    <= '0;
            valid_q <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            keep_q  <= keep_d;
            grant_q <= grant_d;
            oe_q    <= oe_d;
            valid_q <= valid_d;
            idle_q  <= idle_d;
        end
    end

    assign grant     = grant_q;
    assign oe        = oe_q;
    assign bus_valid = valid_q;
    assign idle      = idle_q;

    // Zero-latency pass-through of the owner's data while driving.
    always_comb begin
        bus_out = valid_q ? din_sel : idle_lvl;
    end

endmodule

// File: tb/tb_tbus_arbiter.sv
// Three arbiter configurations on shared stimulus, each checked every cycle
// against a phase-level model, plus literal expectations for key scenarios.
module tb_tbus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;

    logic [3:0] grant_o [3];
    logic [3:0] oe_o    [3];
    logic [7:0] bus_o   [3];
    logic       valid_o [3];
    logic       idle_o  [3];

    always #5 clk = ~clk;

    tbus_arbiter #(.WIDTH(8), .CHANNELS(4), .DEAD(2), .IDLE_MODE(1)) dut0 (
        .clk(clk), .rst(rst), .req(req), .din(din), .grant(grant_o[0]), .oe(oe_o[0]),
        .bus_out(bus_o[0]), .bus_valid(valid_o[0]), .idle(idle_o[0]));
    tbus_arbiter #(.WIDTH(8), .CHANNELS(4), .DEAD(0), .IDLE_MODE(2)) dut1 (
        .clk(clk), .rst(rst), .req(req), .din(din), .grant(grant_o[1]), .oe(oe_o[1]),
        .bus_out(bus_o[1]), .bus_valid(valid_o[1]), .idle(idle_o[1]));
    tbus_arbiter #(.WIDTH(8), .CHANNELS(4), .DEAD(1), .IDLE_MODE(0)) dut2 (
        .clk(clk), .rst(rst), .req(req), .din(din), .grant(grant_o[2]), .oe(oe_o[2]),
        .bus_out(bus_o[2]), .bus_valid(valid_o[2]), .idle(idle_o[2]));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: phase 0 idle, 1 granted, 2 driving, 3 dead time with 'left' cycles to go.
    int         ph   [3];
    int         own  [3];
    int         mptr [3];
    int         left [3];
    logic [7:0] keep [3];
    int         last_oe_cyc [3];
    int         last_oe_own [3];

    function automatic int dead_of(input int n);
        return (n == 0) ? 2 : ((n == 1) ? 0 : 1);
    endfunction

    function automatic int mode_of(input int n);
        return (n == 0) ? 1 : ((n == 1) ? 2 : 0);
    endfunction

    function automatic int pick(input int p, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            ph[n] = 0; own[n] = 0; mptr[n] = 0; left[n] = 0; keep[n] = 8'h00;
            last_oe_cyc[n] = 0; last_oe_own[n] = -1;
        end
    endtask

    task automatic take(input int n, input int w);
        ph[n]   = 1;
        own[n]  = w;
        mptr[n] = (w + 1) % 4;
    endtask

    task automatic model_step(input int n);
        int w;
        w = pick(mptr[n], req);
        case (ph[n])
            0: if (w >= 0) take(n, w);
            1: begin
                if (req[own[n]]) ph[n] = 2;
                else if (dead_of(n) == 0) ph[n] = 0;
                else begin ph[n] = 3; left[n] = dead_of(n); end
            end
            2: begin
                keep[n] = din[own[n]*8 +: 8];
                if (!req[own[n]]) begin
                    if (dead_of(n) != 0) begin ph[n] = 3; left[n] = dead_of(n); end
                    else if (w >= 0) take(n, w);
                    else ph[n] = 0;
                end
            end
            3: begin
                left[n] = left[n] - 1;
                if (left[n] == 0) begin
                    if (w >= 0) take(n, w);
                    else ph[n] = 0;
                end
            end
            default: ph[n] = 0;
        endcase
    endtask

    task automatic compare_all();
        logic [3:0] eg, eo;
        logic [7:0] eb;
        int         o;
        for (int n = 0; n < 3; n++) begin
            eg = (ph[n] == 1 || ph[n] == 2) ? 4'(1 << own[n]) : 4'b0000;
            eo = (ph[n] == 2) ? 4'(1 << own[n]) : 4'b0000;
            if (ph[n] == 2) eb = din[own[n]*8 +: 8];
            else if (mode_of(n) == 0) eb = 8'h00;
            else if (mode_of(n) == 1) eb = 8'hFF;
            else eb = keep[n];
            check($sformatf("grant[%0d]", n), 32'(grant_o[n]), 32'(eg));
            check($sformatf("oe[%0d]", n), 32'(oe_o[n]), 32'(eo));
            check($sformatf("bus_out[%0d]", n), 32'(bus_o[n]), 32'(eb));
            check($sformatf("bus_valid[%0d]", n), 32'(valid_o[n]), 32'(ph[n] == 2));
            check($sformatf("idle[%0d]", n), 32'(idle_o[n]), 32'(ph[n] == 0));
            check($sformatf("oe_onehot0[%0d]", n), 32'($countones(oe_o[n]) <= 1), 32'd1);
            check($sformatf("oe_in_grant[%0d]", n), 32'(oe_o[n] & ~grant_o[n]), 32'd0);
            if (oe_o[n] != 4'b0000) begin
                o = 0;
                for (int i = 0; i < 4; i++) if (oe_o[n][i]) o = i;
                if (last_oe_own[n] >= 0 && o != last_oe_own[n])
                    check($sformatf("dead_gap[%0d]", n),
                          32'((cyc - last_oe_cyc[n] - 1) >= dead_of(n) + 1), 32'd1);
                last_oe_cyc[n] = cyc;
                last_oe_own[n] = o;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int n = 0; n < 3; n++) model_step(n);
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
    endtask

    int dcount;
    int k;
    logic [3:0] prev_oe;

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        din = 32'h0;
        model_reset();

        // Idle level with no requests.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("idle_pullup_bus", 32'(bus_o[0]), 32'h0000_00FF);
            check("idle_flag", 32'(idle_o[0]), 32'd1);
            check("idle_oe", 32'(oe_o[0]), 32'd0);
        end

        // Single requester, then release through the dead time.
        do_reset();
        req = 4'b0001;
        din = $urandom;
        din[7:0] = 8'hA5;
        cycle();
        check("single_grant", 32'(grant_o[0]), 32'h1);
        check("single_grant_oe", 32'(oe_o[0]), 32'h0);
        cycle();
        check("single_oe", 32'(oe_o[0]), 32'h1);
        check("single_bus", 32'(bus_o[0]), 32'hA5);
        check("single_valid", 32'(valid_o[0]), 32'd1);
        req = 4'b0000;
        cycle();
        check("release_oe", 32'(oe_o[0]), 32'h0);
        check("turn1_idle", 32'(idle_o[0]), 32'd0);
        cycle();
        check("turn2_idle", 32'(idle_o[0]), 32'd0);
        cycle();
        check("back_idle", 32'(idle_o[0]), 32'd1);

        // All channels requesting; each owner briefly drops after three drive cycles.
        do_reset();
        req = 4'b1111;
        dcount = 0;
        k = 0;
        prev_oe = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (oe_o[0] != 4'b0000 && prev_oe == 4'b0000) begin
                check("rr_order", 32'(oe_o[0]), 32'(1 << (k % 4)));
                k++;
            end
            prev_oe = oe_o[0];
            dcount = (ph[0] == 2) ? dcount + 1 : 0;
            req = 4'b1111;
            if (dcount == 3) req[own[0]] = 1'b0;
        end
        check("rr_tenures", 32'(k >= 6), 32'd1);

        // Keeper holds the last driven value; pulldown reads zero.
        do_reset();
        req = 4'b0100;
        din = 32'h0;
        din[23:16] = 8'h3C;
        cycle();
        cycle();
        req = 4'b0000;
        cycle();
        din = 32'h0;
        check("keeper_hold", 32'(bus_o[1]), 32'h3C);
        check("pulldown_turn", 32'(bus_o[2]), 32'h00);
        cycle();
        check("keeper_idle", 32'(bus_o[1]), 32'h3C);
        check("keeper_idle_flag", 32'(idle_o[1]), 32'd1);

        // Zero dead time: direct handover inserts exactly one GRANT cycle.
        do_reset();
        din = $urandom;
        req = 4'b0010;
        cycle();
        cycle();
        req = 4'b1010;
        cycle();
        check("d0_owner1", 32'(oe_o[1]), 32'h2);
        req = 4'b1000;
        cycle();
        check("d0_grant3", 32'(grant_o[1]), 32'h8);
        check("d0_gap_oe", 32'(oe_o[1]), 32'h0);
        cycle();
        check("d0_drive3", 32'(oe_o[1]), 32'h8);

        // Asynchronous reset in the middle of a drive.
        do_reset();
        req = 4'b0100;
        din = $urandom;
        cycle();
        cycle();
        check("pre_rst_oe", 32'(oe_o[0]), 32'h4);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_oe", 32'(oe_o[0]), 32'h0);
        check("async_rst_valid", 32'(valid_o[0]), 32'd0);
        check("async_rst_bus", 32'(bus_o[0]), 32'hFF);
        check("async_rst_keeper", 32'(bus_o[1]), 32'h00);
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        cycle();
        check("post_rst_ptr0", 32'(grant_o[0]), 32'h1);

        // Randomised traffic.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            din = $urandom;
            for (int c = 0; c < 4; c++) begin
                if (req[c]) begin
                    if ($urandom_range(0, 7) == 0) req[c] = 1'b0;
                end else if ($urandom_range(0, 5) == 0) begin
                    req[c] = 1'b1;
                end
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
